kyber_xchg_sched: RTL and testbench

- Sequences one full Kyber key exchange between a Kyber server core and a Kyber client core: keygen, public-key transfer, encaps, ciphertext transfer, decaps.
- Owns the single shared 32-bit inter-core word channel and steers it server->client or client->server according to phase.
- Sits directly above the two cores in the top level.
- Drives their start/k inputs and counts the words moved in each direction.

---
 rtl/kyber_xchg_sched.sv | 212 +++++++++++++++++++++
 tb/tb_kyber_xchg_sched.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kyber_xchg_sched.sv
`timescale 1ns/1ps
// Key-exchange sequencer: keygen -> pk transfer -> encaps -> ct transfer -> decaps,
// steering the single shared 32-bit word channel between server and client cores.
module kyber_xchg_sched #(
   parameter int TIMEOUT = 65535,
   parameter int CW      = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        go,
   input  logic [2:0]  k_in,
   output logic [2:0]  k_out,
   output logic [1:0]  start_s,
   output logic [1:0]  start_c,
   input  logic        ready_pk_s,
   input  logic        ready_c_c,
   input  logic        done_s,
   input  logic        valid_s,
   input  logic [31:0] dout_s,
   input  logic        valid_c,
   input  logic [31:0] dout_c,
   output logic        wen_c,
   output logic [31:0] din_c,
   output logic        wen_s,
   output logic [31:0] din_s,
   output logic        busy,
   output logic        done,
   output logic [1:0]  err
);

   typedef enum logic [2:0] {
      S_IDLE, S_KG, S_PK, S_ENC, S_CT, S_DEC, S_FIN
   } state_t;

   localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] WD_ONE  = CW'(1);

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_K       = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;
   localparam logic [1:0] ERR_OVERRUN = 2'b11;

   state_t        state_q, state_d;
   logic [2:0]    k_q, k_d;
   logic [8:0]    cnt_q, cnt_d;
   logic [CW-1:0] wd_q, wd_d;
   logic [1:0]    err_q, err_d;
   logic [1:0]    start_s_q, start_s_d;
   logic [1:0]    start_c_q, start_c_d;
   logic          tail_q, tail_d;

   logic          k_legal;
   logic          wd_expired;
   logic [8:0]    pk_last;
   logic [8:0]    ct_last;

   assign k_legal    = (k_in == 3'd2) || (k_in == 3'd3) || (k_in == 3'd4);
   assign wd_expired = (wd_q == WD_LAST);

   // Index of the final word in each transfer for the latched rank.
   always_comb begin
      pk_last = 9'd199;
      ct_last = 9'd191;
      case (k_q)
         3'd3: begin
            pk_last = 9'd295;
            ct_last = 9'd271;
         end
         3'd4: begin
            pk_last = 9'd391;
            ct_last = 9'd391;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      cnt_d     = cnt_q;
      wd_d      = wd_q + WD_ONE;
      err_d     = err_q;
      start_s_d = 2'b00;
      start_c_d = 2'b00;
      tail_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            wd_d  = '0;
            cnt_d = '0;
            if (go) begin
               if (k_legal) begin
                  state_d   = S_KG;
                  k_d       = k_in;
                  err_d     = ERR_NONE;
                  start_s_d = 2'b01;
               end else begin
                  err_d = ERR_K;
               end
            end
         end
         S_KG: begin
            if (ready_pk_s) begin
               state_d = S_PK;
               cnt_d   = '0;
            end else if (wd_expired) begin
               state_d = S_IDLE;
               err_d   = ERR_TIMEOUT;
            end
         end
         S_PK: begin
            // An accepted word beats a simultaneous watchdog expiry.
            if (valid_s) begin
               wd_d  = '0;
               cnt_d = cnt_q + 9'd1;
               if (cnt_q == pk_last) begin
                  state_d   = S_ENC;
                  start_c_d = 2'b01;
                  tail_d    = 1'b1;
                  cnt_d     = '0;
               end
            end else if (wd_expired) begin
               state_d = S_IDLE;
               err_d   = ERR_TIMEOUT;
            end
         end
         S_ENC: begin
            if (tail_q && valid_s) begin
               state_d = S_IDLE;
               err_d   = ERR_OVERRUN;
            end else if (ready_c_c) begin
               state_d = S_CT;
               cnt_d   = '0;
            end else if (wd_expired) begin
               state_d = S_IDLE;
               err_d   = ERR_TIMEOUT;
            end
         end
         S_CT: begin
            if (valid_c) begin
               wd_d  = '0;
               cnt_d = cnt_q + 9'd1;
               if (cnt_q == ct_last) begin
                  state_d   = S_DEC;
                  start_s_d = 2'b10;
                  tail_d    = 1'b1;
                  cnt_d     = '0;
               end
            end else if (wd_expired) begin
               state_d = S_IDLE;
               err_d   = ERR_TIMEOUT;
            end
         end
         S_DEC: begin
            if (tail_q && valid_c) begin
               state_d = S_IDLE;
               err_d   = ERR_OVERRUN;
            end else if (done_s) begin
               state_d = S_FIN;
            end else if (wd_expired) begin
               state_d = S_IDLE;
               err_d   = ERR_TIMEOUT;
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (state_d != state_q) begin
         wd_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         k_q       <= '0;
         cnt_q     <= '0;
         wd_q      <= '0;
         err_q     <= ERR_NONE;
         start_s_q <= 2'b00;
         start_c_q <= 2'b00;
         tail_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         cnt_q     <= cnt_d;
         wd_q      <= wd_d;
         err_q     <= err_d;
         start_s_q <= start_s_d;
         start_c_q <= start_c_d;
         tail_q    <= tail_d;
      end
   end

   // Everything is forced quiet while rst is high, including the pass-through path.
   assign k_out   = rst ? 3'd0 : k_q;
   assign start_s = rst ? 2'b00 : start_s_q;
   assign start_c = rst ? 2'b00 : start_c_q;
   assign err     = rst ? 2'b00 : err_q;
   assign busy    = !rst && (state_q != S_IDLE);
   assign done    = !rst && (state_q == S_FIN);
   assign wen_c   = !rst && (state_q == S_PK) && valid_s;
   assign wen_s   = !rst && (state_q == S_CT) && valid_c;
   assign din_c   = wen_c ? dout_s : 32'd0;
   assign din_s   = wen_s ? dout_c : 32'd0;

endmodule

// File: tb/tb_kyber_xchg_sched.sv
`timescale 1ns/1ps
// Directed bench for kyber_xchg_sched: table of full exchanges plus hand-written
// illegal-k, watchdog, overrun and mid-run reset sequences.
module tb_kyber_xchg_sched;

   localparam int TO = 100;

   logic        clk = 1'b0;
   logic        rst;
   logic        go;
   logic [2:0]  k_in;
   logic [2:0]  k_out;
   logic [1:0]  start_s;
   logic [1:0]  start_c;
   logic        ready_pk_s;
   logic        ready_c_c;
   logic        done_s;
   logic        valid_s;
   logic [31:0] dout_s;
   logic        valid_c;
   logic [31:0] dout_c;
   logic        wen_c;
   logic [31:0] din_c;
   logic        wen_s;
   logic [31:0] din_s;
   logic        busy;
   logic        done;
   logic [1:0]  err;

   always #5 clk = ~clk;

   kyber_xchg_sched #(.TIMEOUT(TO), .CW(16)) dut (
      .clk(clk), .rst(rst), .go(go), .k_in(k_in), .k_out(k_out),
      .start_s(start_s), .start_c(start_c),
      .ready_pk_s(ready_pk_s), .ready_c_c(ready_c_c), .done_s(done_s),
      .valid_s(valid_s), .dout_s(dout_s), .valid_c(valid_c), .dout_c(dout_c),
      .wen_c(wen_c), .din_c(din_c), .wen_s(wen_s), .din_s(din_s),
      .busy(busy), .done(done), .err(err)
   );

   typedef struct {
      logic [2:0] k;
      int         gap;
      int         rdly;
      int         pkw;
      int         ctw;
   } vec_t;

   vec_t vecs [3];

   int n_tests = 0;
   int n_fail  = 0;
   int n_kg, n_enc, n_dec, n_bad, n_wc, n_ws, n_dmis, n_done;

   function automatic logic [31:0] pat_s(input int i);
      return 32'hA5000000 ^ 32'(i * 7919);
   endfunction

   function automatic logic [31:0] pat_c(input int i);
      return 32'h3C000000 ^ 32'(i * 104729);
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic clr();
      n_kg = 0; n_enc = 0; n_dec = 0; n_bad = 0;
      n_wc = 0; n_ws = 0; n_dmis = 0; n_done = 0;
   endtask

   // Sample 2 ns after the falling edge, once inputs for this cycle are applied.
   task automatic sample_cyc();
      #2;
      if (start_s == 2'b01) n_kg++;
      if (start_s == 2'b10) n_dec++;
      if (start_s == 2'b11) n_bad++;
      if (start_c == 2'b01) n_enc++;
      if (start_c[1]) n_bad++;
      if (wen_c) begin
         if (din_c !== pat_s(n_wc)) n_dmis++;
         n_wc++;
      end
      if (wen_s) begin
         if (din_s !== pat_c(n_ws)) n_dmis++;
         n_ws++;
      end
      if (done) n_done++;
   endtask

   task automatic next_cyc();
      @(negedge clk);
   endtask

   task automatic tick();
      sample_cyc();
      next_cyc();
   endtask

   task automatic run_xchg(input logic [2:0] k, input int gap, input int rdly,
                           input int pkw, input int ctw);
      clr();
      go = 1'b1; k_in = k;
      tick();
      go = 1'b0; k_in = 3'd0;
      sample_cyc();
      check("xchg_k_out", 32'(k_out), 32'(k));
      check("xchg_busy_kg", 32'(busy), 32'd1);
      check("xchg_err_cleared", 32'(err), 32'd0);
      next_cyc();
      for (int i = 1; i < rdly; i++) tick();
      ready_pk_s = 1'b1;
      tick();
      ready_pk_s = 1'b0;
      for (int i = 0; i < pkw; i++) begin
         valid_s = 1'b1; dout_s = pat_s(i);
         valid_c = 1'b1; dout_c = 32'hDEAD0000 | 32'(i);
         tick();
         valid_s = 1'b0; dout_s = '0; valid_c = 1'b0; dout_c = '0;
         for (int g = 0; g < gap; g++) tick();
      end
      tick();
      tick();
      ready_c_c = 1'b1;
      tick();
      ready_c_c = 1'b0;
      for (int i = 0; i < ctw; i++) begin
         valid_c = 1'b1; dout_c = pat_c(i);
         valid_s = 1'b1; dout_s = 32'hBEEF0000 | 32'(i);
         tick();
         valid_s = 1'b0; dout_s = '0; valid_c = 1'b0; dout_c = '0;
         for (int g = 0; g < gap; g++) tick();
      end
      tick();
      tick();
      tick();
      done_s = 1'b1;
      tick();
      done_s = 1'b0;
      tick();
      sample_cyc();
      check("xchg_busy_after", 32'(busy), 32'd0);
      check("xchg_err_after", 32'(err), 32'd0);
      next_cyc();
      check("xchg_start_kg", 32'(n_kg), 32'd1);
      check("xchg_start_enc", 32'(n_enc), 32'd1);
      check("xchg_start_dec", 32'(n_dec), 32'd1);
      check("xchg_bad_start", 32'(n_bad), 32'd0);
      check("xchg_wen_c_count", 32'(n_wc), 32'(pkw));
      check("xchg_wen_s_count", 32'(n_ws), 32'(ctw));
      check("xchg_data", 32'(n_dmis), 32'd0);
      check("xchg_done", 32'(n_done), 32'd1);
      $display("[TB] exchange k=%0d gap=%0d: %0d pk words, %0d ct words, done=%0d",
               k, gap, n_wc, n_ws, n_done);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL bench_timeout: simulation did not finish, expected completion");
      $fatal(1, "bench timeout");
   end

   initial begin
      vecs[0] = '{k: 3'd2, gap: 0, rdly: 10, pkw: 200, ctw: 192};
      vecs[1] = '{k: 3'd4, gap: 2, rdly: 3,  pkw: 392, ctw: 392};
      vecs[2] = '{k: 3'd3, gap: 1, rdly: 6,  pkw: 296, ctw: 272};

      rst = 1'b1; go = 1'b0; k_in = 3'd0;
      ready_pk_s = 1'b0; ready_c_c = 1'b0; done_s = 1'b0;
      valid_s = 1'b0; dout_s = '0; valid_c = 1'b0; dout_c = '0;
      clr();
      next_cyc();
      sample_cyc();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_k_out", 32'(k_out), 32'd0);
      check("rst_start_s", 32'(start_s), 32'd0);
      check("rst_start_c", 32'(start_c), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_wen", {30'd0, wen_c, wen_s}, 32'd0);
      next_cyc();
      rst = 1'b0;
      tick();
      $display("[TB] reset state checked");

      // Illegal rank
      clr();
      go = 1'b1; k_in = 3'd5;
      tick();
      go = 1'b0; k_in = 3'd0;
      sample_cyc();
      check("illegal_err", 32'(err), 32'd1);
      check("illegal_busy", 32'(busy), 32'd0);
      next_cyc();
      tick();
      check("illegal_no_start", 32'(n_kg), 32'd0);
      $display("[TB] illegal k=5 go: err=%0d", err);

      run_xchg(3'd3, 0, 4, 296, 272);

      for (int v = 0; v < 3; v++) begin
         run_xchg(vecs[v].k, vecs[v].gap, vecs[v].rdly, vecs[v].pkw, vecs[v].ctw);
      end

      // Server stalls in keygen: abort exactly TO cycles after KG entry
      clr();
      go = 1'b1; k_in = 3'd2;
      tick();
      go = 1'b0;
      for (int i = 0; i < TO - 1; i++) tick();
      sample_cyc();
      check("to_busy_before", 32'(busy), 32'd1);
      check("to_err_before", 32'(err), 32'd0);
      next_cyc();
      sample_cyc();
      check("to_err", 32'(err), 32'd2);
      check("to_busy", 32'(busy), 32'd0);
      next_cyc();
      tick();
      check("to_no_done", 32'(n_done), 32'd0);
      $display("[TB] keygen stall: err=%0d", err);

      // Overrun: 201st server word straight after the 200th
      clr();
      go = 1'b1; k_in = 3'd2;
      tick();
      go = 1'b0;
      ready_pk_s = 1'b1;
      tick();
      ready_pk_s = 1'b0;
      for (int i = 0; i < 200; i++) begin
         valid_s = 1'b1; dout_s = pat_s(i);
         tick();
      end
      dout_s = pat_s(200);
      sample_cyc();
      check("ovr_not_fwd", 32'(wen_c), 32'd0);
      next_cyc();
      valid_s = 1'b0; dout_s = '0;
      sample_cyc();
      check("ovr_err", 32'(err), 32'd3);
      check("ovr_busy", 32'(busy), 32'd0);
      next_cyc();
      tick();
      check("ovr_fwd_count", 32'(n_wc), 32'd200);
      check("ovr_no_done", 32'(n_done), 32'd0);
      $display("[TB] overrun: err=%0d forwarded=%0d", err, n_wc);

      // Reset in the middle of the public-key transfer
      clr();
      go = 1'b1; k_in = 3'd2;
      tick();
      go = 1'b0;
      ready_pk_s = 1'b1;
      tick();
      ready_pk_s = 1'b0;
      for (int i = 0; i < 50; i++) begin
         valid_s = 1'b1; dout_s = pat_s(i);
         tick();
      end
      rst = 1'b1;
      dout_s = pat_s(50);
      sample_cyc();
      check("midrst_wen_c", 32'(wen_c), 32'd0);
      check("midrst_din_c", din_c, 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_k_out", 32'(k_out), 32'd0);
      check("midrst_starts", {28'd0, start_s, start_c}, 32'd0);
      next_cyc();
      rst = 1'b0; valid_s = 1'b0; dout_s = '0;
      tick();
      $display("[TB] mid-transfer reset applied after %0d words", n_wc);
      run_xchg(3'd3, 0, 2, 296, 272);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
